mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between instruction fetch (IF) and data load/store (D).
//  Round-robin arbitration, one outstanding transaction, req/ack handshake per requester,
//  mem_req/mem_ready handshake to memory with timeout abort.
//  Address selection goes through a 2-way 32-bit mux whose select is the registered grant.
// PARAMETERS
//  ADDR_W   32  address width (mux instance is 32-bit; ADDR_W must equal 32)
//  DATA_W   32  data width
//  TIMEOUT  16  BUSY cycles without mem_ready before abort (>=1)
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  if_req     in   1       IF request; held with if_addr until if_ack
//  if_addr    in   ADDR_W  IF address
//  if_ack     out  1       1-cycle pulse, IF transaction done
//  if_rdata   out  DATA_W  IF read data, valid with if_ack, held until next IF completion
//  d_req      in   1       D request; held with d_we/d_addr/d_wdata until d_ack
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  D address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       1-cycle pulse, D transaction done
//  d_rdata    out  DATA_W  D load data, valid with d_ack, held until next D completion
//  mem_req    out  1       memory request, high throughout BUSY
//  mem_we     out  1       write enable (always 0 for IF grant)
//  mem_addr   out  ADDR_W  mux output: if_addr when grant=0, d_addr when grant=1
//  mem_wdata  out  DATA_W  d_wdata when grant=1, else 0
//  mem_rdata  in   DATA_W  memory read data, sampled on the edge mem_req&mem_ready
//  mem_ready  in   1       memory completion
//  grant      out  1       0=IF, 1=D; mux select; changes only on IDLE->BUSY
//  err        out  1       1-cycle pulse with the ack of a timed-out transaction
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant=0, last=1, all acks/err/mem_req/mem_we=0,
//   if_rdata=d_rdata=0, timeout counter=0. Reset mid-BUSY drops mem_req at once; no ack issued.
//  FSM IDLE->BUSY->DONE->IDLE.
//  IDLE: only one req -> grant it; both -> grant !last. Any req: grant<=choice, ->BUSY. None: stay.
//  BUSY: mem_req=1, mem_we=grant&d_we. On edge with mem_ready=1: capture mem_rdata into the
//   granted rdata reg, ->DONE. Counter increments per BUSY cycle without ready; at TIMEOUT:
//   ->DONE with abort flag, granted rdata<=all-ones.
//  DONE: granted ack=1 (plus err if aborted), last<=grant, mem_req=0, ->IDLE.
//  Min latency req-sampled to ack: 2 cycles (BUSY, DONE); min issue interval 3 cycles.
//  Requester clears req on the edge that samples ack -> IDLE sees new req; no double grant.
//  Requests arriving during BUSY/DONE wait until IDLE; req dropped mid-transaction is ignored:
//   transaction completes, ack still pulses.
//  mem_ready outside BUSY ignored. Counter width $clog2(TIMEOUT+1), cleared on entering BUSY.
//  Ack/err registered outputs: never high in IDLE or BUSY, never both acks at once.
// STRUCTURE
//  Shared package mips_pkg: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2; GRANT_IF=1'b0,
//   GRANT_D=1'b1; MEM_ERR_DATA=32'hFFFF_FFFF.
//  One sub-module: existing Mux2way32 instance for mem_addr (a=if_addr, b=d_addr, sel=grant).
//  Rest (FSM, counter, rdata regs) flat in this module.
// TESTING
//  1 Assert rst_n=0 mid-BUSY (mem_ready=0) -> same cycle mem_req=0, grant=0, acks=0, err=0.
//  2 if_req, if_addr=0x0040_0000, mem_ready=1, mem_rdata=0x2008_0005 -> mem_addr=0x0040_0000,
//    mem_we=0, if_ack 2 cycles after req sampled, if_rdata=0x2008_0005, d_ack stays 0.
//  3 if_req and d_req held high continuously after reset, mem_ready=1 -> grant sequence IF,D,IF,D;
//    acks alternate, one every 3 cycles.
//  4 d_we=1, d_addr=0x1001_0000, d_wdata=0xCAFE_F00D, mem_ready after 3 cycles -> mem_req high
//    4 cycles with stable addr/wdata/mem_we=1; d_ack the cycle after ready; err=0.
//  5 TIMEOUT=16, d_req load, mem_ready=0 -> mem_req high 16 cycles then low; d_ack and err pulse
//    together; d_rdata=0xFFFF_FFFF; next IF request served normally.
//  6 d_req raised while IF in BUSY -> no grant change until IDLE; D granted immediately after if_ack.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the memory-port arbiter: FSM encodings, grant values and abort data.
package mips_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    localparam logic [31:0] MEM_ERR_DATA = 32'hFFFF_FFFF;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    function automatic logic pick_grant(input logic if_req, input logic d_req, input logic last);
        if (if_req && d_req)
            return ~last;
        return d_req ? GRANT_D : GRANT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              grant;
    logic              err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               grant, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               grant, err
    );

endinterface

// File: rtl/Mux2way32.sv
// Plain 2-way 32-bit multiplexer: sel=0 passes a, sel=1 passes b.
module Mux2way32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// one transaction in flight, with a BUSY-cycle timeout that aborts and returns all-ones.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             choice;

    assign choice = pick_grant(bus.if_req, bus.d_req, last);

    // mem_req decodes straight from state so an async reset drops it in the same cycle.
    assign bus.mem_req   = (state == ST_BUSY);
    assign bus.mem_we    = (state == ST_BUSY) && (bus.grant == GRANT_D) && bus.d_we;
    assign bus.mem_wdata = (bus.grant == GRANT_D) ? bus.d_wdata : '0;

    Mux2way32 u_addr_mux (
        .a   (bus.if_addr),
        .b   (bus.d_addr),
        .sel (bus.grant),
        .y   (bus.mem_addr)
    );

    // Acks and err are set on the BUSY->DONE edge, so they are high exactly while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bus.grant    <= GRANT_IF;
            last         <= 1'b1;
            cnt          <= '0;
            bus.if_ack   <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.err      <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        bus.grant <= choice;
                        cnt       <= '0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ready) begin
                        if (bus.grant == GRANT_D)
                            bus.d_rdata <= bus.mem_rdata;
                        else
                            bus.if_rdata <= bus.mem_rdata;
                        bus.if_ack <= (bus.grant == GRANT_IF);
                        bus.d_ack  <= (bus.grant == GRANT_D);
                        state      <= ST_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        if (bus.grant == GRANT_D)
                            bus.d_rdata <= MEM_ERR_DATA;
                        else
                            bus.if_rdata <= MEM_ERR_DATA;
                        bus.if_ack <= (bus.grant == GRANT_IF);
                        bus.d_ack  <= (bus.grant == GRANT_D);
                        bus.err    <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    last  <= bus.grant;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                                 input logic d_req, input logic d_we,
                                 input logic [31:0] d_addr, input logic [31:0] d_wdata,
                                 input logic mem_ready, input logic [31:0] mem_rdata);
        bus.if_req    = if_req;
        bus.if_addr   = if_addr;
        bus.d_req     = d_req;
        bus.d_we      = d_we;
        bus.d_addr    = d_addr;
        bus.d_wdata   = d_wdata;
        bus.mem_ready = mem_ready;
        bus.mem_rdata = mem_rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        #12;
        checkOutput("rst_grant", bus.grant, 0);
        checkOutput("rst_mem_req", bus.mem_req, 0);
        checkOutput("rst_acks", {bus.if_ack, bus.d_ack, bus.err}, 0);
        checkOutput("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
        rst_n = 1'b1;
        step();

        // Single IF fetch, memory ready at once
        $display("[TB] single IF fetch");
        applyStimulus(1, 32'h0040_0000, 0, 0, 32'h0, 32'h0, 1, 32'h2008_0005);
        step();
        checkOutput("if_busy_req", bus.mem_req, 1);
        checkOutput("if_busy_addr", bus.mem_addr, 32'h0040_0000);
        checkOutput("if_busy_we", bus.mem_we, 0);
        checkOutput("if_busy_ack", bus.if_ack, 0);
        step();
        checkOutput("if_done_ack", bus.if_ack, 1);
        checkOutput("if_done_rdata", bus.if_rdata, 32'h2008_0005);
        checkOutput("if_done_dack", {bus.d_ack, bus.err, bus.mem_req}, 0);
        step();
        checkOutput("if_idle_ack", bus.if_ack, 0);
        bus.if_req = 1'b0;

        // D request arrives while IF is BUSY
        $display("[TB] D request during IF transaction");
        applyStimulus(1, 32'h0040_0004, 0, 0, 32'h1001_0000, 32'h0, 0, 32'h1111_2222);
        step();
        checkOutput("ovl_grant_if", bus.grant, GRANT_IF);
        bus.d_req = 1'b1;
        step();
        checkOutput("ovl_grant_hold", bus.grant, GRANT_IF);
        checkOutput("ovl_addr_hold", bus.mem_addr, 32'h0040_0004);
        bus.mem_ready = 1'b1;
        step();
        checkOutput("ovl_if_ack", {bus.if_ack, bus.d_ack}, 2'b10);
        checkOutput("ovl_grant_done", bus.grant, GRANT_IF);
        step();
        bus.if_req    = 1'b0;
        bus.mem_rdata = 32'h1234_5678;
        step();
        checkOutput("ovl_grant_d", bus.grant, GRANT_D);
        checkOutput("ovl_addr_d", bus.mem_addr, 32'h1001_0000);
        step();
        checkOutput("ovl_d_ack", {bus.if_ack, bus.d_ack}, 2'b01);
        checkOutput("ovl_d_rdata", bus.d_rdata, 32'h1234_5678);
        step();
        bus.d_req = 1'b0;

        // Store with ready in the fourth BUSY cycle
        $display("[TB] store with wait states");
        applyStimulus(0, 32'h0, 1, 1, 32'h1001_0000, 32'hCAFE_F00D, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("st_req", bus.mem_req, 1);
            checkOutput("st_bus", {bus.mem_addr, bus.mem_wdata}, {32'h1001_0000, 32'hCAFE_F00D});
            checkOutput("st_we", bus.mem_we, 1);
            checkOutput("st_ack_early", bus.d_ack, 0);
        end
        bus.mem_ready = 1'b1;
        step();
        checkOutput("st_ack", {bus.d_ack, bus.err, bus.mem_req}, 3'b100);
        step();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Load that never gets ready -> timeout abort
        $display("[TB] load timeout");
        applyStimulus(0, 32'h0, 1, 0, 32'h1001_0040, 32'h0, 0, 32'h5555_5555);
        step();
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            step();
        end
        checkOutput("to_busy_cycles", n, 16);
        checkOutput("to_ack_err", {bus.d_ack, bus.err, bus.if_ack}, 3'b110);
        checkOutput("to_rdata", bus.d_rdata, 32'hFFFF_FFFF);
        step();
        checkOutput("to_err_clear", bus.err, 0);
        bus.d_req = 1'b0;

        applyStimulus(1, 32'h0040_0008, 0, 0, 32'h0, 32'h0, 1, 32'hAAAA_5555);
        step();
        checkOutput("post_to_grant", bus.grant, GRANT_IF);
        step();
        checkOutput("post_to_ack", {bus.if_ack, bus.err}, 2'b10);
        checkOutput("post_to_rdata", bus.if_rdata, 32'hAAAA_5555);
        step();
        bus.if_req = 1'b0;

        // Reset in the middle of a D transaction
        $display("[TB] reset mid-BUSY");
        applyStimulus(0, 32'h0, 1, 1, 32'h1001_0080, 32'h0BAD_0BAD, 0, 32'h0);
        step();
        checkOutput("mid_grant_d", bus.grant, GRANT_D);
        checkOutput("mid_req", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req_we", {bus.mem_req, bus.mem_we}, 0);
        checkOutput("mid_rst_grant", bus.grant, GRANT_IF);
        checkOutput("mid_rst_flags", {bus.if_ack, bus.d_ack, bus.err}, 0);
        checkOutput("mid_rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);

        // Both requesters held continuously after reset
        $display("[TB] continuous contention");
        applyStimulus(1, 32'h0040_0010, 1, 0, 32'h1001_0010, 32'h0, 1, 32'h0F0F_0F0F);
        #2 rst_n = 1'b1;
        step();
        for (int k = 1; k <= 12; k++) begin
            logic exp_grant;
            exp_grant = ((k - 1) / 3) % 2 == 1;
            if (k % 3 == 1) begin
                checkOutput($sformatf("rr_busy_%0d", k), {bus.mem_req, bus.grant}, {1'b1, exp_grant});
                checkOutput($sformatf("rr_addr_%0d", k), bus.mem_addr,
                            exp_grant ? 32'h1001_0010 : 32'h0040_0010);
            end
            if (k % 3 == 2)
                checkOutput($sformatf("rr_ack_%0d", k), {bus.if_ack, bus.d_ack},
                            exp_grant ? 2'b01 : 2'b10);
            else
                checkOutput($sformatf("rr_noack_%0d", k), {bus.if_ack, bus.d_ack}, 2'b00);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
